// File: rtl/dmem_arbiter.sv
// Two-master arbiter/controller for the CPU data memory: fixed priority to the
// MEM stage, anti-starvation escalation and burst lock for the debug/DMA master.
module dmem_arbiter #(
  parameter logic [31:0] BASE_ADDR = 32'h1001_0000,
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned MAX_WAIT  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_wen,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  output logic        m0_stall,
  input  logic        m1_req,
  input  logic        m1_wen,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic        m1_lock,
  output logic        m1_gnt,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        mem_ena,
  output logic        mem_wena,
  output logic [31:0] mem_addr_in,
  output logic [31:0] mem_addr_out,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        locked
);

  localparam int unsigned WAIT_W    = 8;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
  localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(4 * MEM_WORDS) - 32'd4;

  if (MAX_WAIT == 0 || MAX_WAIT > 255) begin : g_bad_max_wait
    $error("dmem_arbiter: MAX_WAIT must be in 1..255");
  end

  typedef enum logic {NORMAL = 1'b0, LOCKED = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic [31:0]       sel_addr, sel_wdata;
  logic              sel_wen, legal;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= NORMAL;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  assign locked = (state == LOCKED);

  // Grant, transaction mapping and next-state; everything held at 0 in reset.
  always_comb begin
    m0_gnt       = 1'b0;
    m1_gnt       = 1'b0;
    m0_err       = 1'b0;
    m1_err       = 1'b0;
    m0_stall     = 1'b0;
    m0_rdata     = 32'h0;
    m1_rdata     = 32'h0;
    mem_ena      = 1'b0;
    mem_wena     = 1'b0;
    mem_addr_in  = 32'h0;
    mem_addr_out = 32'h0;
    mem_wdata    = 32'h0;
    sel_addr     = 32'h0;
    sel_wdata    = 32'h0;
    sel_wen      = 1'b0;
    legal        = 1'b0;
    state_nxt    = state;
    wait_nxt     = wait_cnt;

    if (rst) begin
      if (state == LOCKED) begin
        m1_gnt = m1_req;
      end else if (wait_cnt >= WAIT_MAX) begin
        m1_gnt = m1_req;
        m0_gnt = m0_req & ~m1_req;
      end else begin
        m0_gnt = m0_req;
        m1_gnt = m1_req & ~m0_req;
      end
      m0_stall = m0_req & ~m0_gnt;

      if (m0_gnt) begin
        sel_addr  = m0_addr;
        sel_wdata = m0_wdata;
        sel_wen   = m0_wen;
      end else if (m1_gnt) begin
        sel_addr  = m1_addr;
        sel_wdata = m1_wdata;
        sel_wen   = m1_wen;
      end

      legal = (sel_addr[1:0] == 2'b00) && (sel_addr >= BASE_ADDR) && (sel_addr <= LAST_ADDR);

      if (m0_gnt || m1_gnt) begin
        mem_addr_in  = sel_addr;
        mem_addr_out = sel_addr;
        mem_wdata    = sel_wdata;
        mem_ena      = legal;
        mem_wena     = legal & sel_wen;
      end

      // Illegal accesses still consume the grant but return zero and flag err.
      m0_err   = m0_gnt & ~legal;
      m1_err   = m1_gnt & ~legal;
      m0_rdata = (m0_gnt && legal && !m0_wen) ? mem_rdata : 32'h0;
      m1_rdata = (m1_gnt && legal && !m1_wen) ? mem_rdata : 32'h0;

      if (m1_req && !m1_gnt) begin
        wait_nxt = (wait_cnt >= WAIT_MAX) ? WAIT_MAX : wait_cnt + WAIT_W'(1);
      end else begin
        wait_nxt = '0;
      end

      case (state)
        NORMAL: if (m1_gnt && m1_lock) state_nxt = LOCKED;
        LOCKED: if ((m1_gnt && !m1_lock) || (!m1_req && !m1_lock)) state_nxt = NORMAL;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: vector table plus hand-written
// starvation, lock-burst and asynchronous-reset sequences against a memory model.
module tb_dmem_arbiter;

  localparam logic [31:0] B = 32'h1001_0000;
  localparam logic [31:0] A = 32'h1001_0010;

  typedef struct packed {
    logic        m0_gnt, m1_gnt, m0_err, m1_err, m0_stall, mem_ena, mem_wena, locked;
    logic [31:0] m0_rdata, m1_rdata, addr_in, addr_out;
  } out_t;

  typedef struct {
    string       name;
    logic        rst, m0_req, m0_wen, m1_req, m1_wen, m1_lock;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    out_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_wen, m1_req, m1_wen, m1_lock;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_err, m0_stall, m1_gnt, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_ena, mem_wena, locked;
  logic [31:0] mem_addr_in, mem_addr_out, mem_wdata, mem_rdata;

  logic [31:0] mem [1024];

  int checks   = 0;
  int failures = 0;

  out_t  exp_q [$];
  string name_q[$];
  vec_t  tbl   [$];

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_err(m0_err), .m0_stall(m0_stall),
    .m1_req(m1_req), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_ena(mem_ena), .mem_wena(mem_wena), .mem_addr_in(mem_addr_in),
    .mem_addr_out(mem_addr_out), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .locked(locked)
  );

  // Data memory model: combinational read, Z when disabled, write on posedge.
  assign mem_rdata = mem_ena ? mem[10'((mem_addr_out - B) >> 2)] : 32'hzzzz_zzzz;
  always @(posedge clk) if (mem_ena && mem_wena) mem[10'((mem_addr_in - B) >> 2)] <= mem_wdata;

  function automatic out_t ex(input bit g0, g1, e0, e1, st, ena, wena, lk,
                              input logic [31:0] rd0, rd1, addr);
    out_t o;
    o.m0_gnt = g0; o.m1_gnt = g1; o.m0_err = e0; o.m1_err = e1; o.m0_stall = st;
    o.mem_ena = ena; o.mem_wena = wena; o.locked = lk;
    o.m0_rdata = rd0; o.m1_rdata = rd1; o.addr_in = addr; o.addr_out = addr;
    return o;
  endfunction

  function automatic vec_t mk(input string n, input bit r, q0, w0, input logic [31:0] a0, d0,
                              input bit q1, w1, input logic [31:0] a1, d1, input bit lk,
                              input out_t e);
    vec_t v;
    v.name = n; v.rst = r; v.m0_req = q0; v.m0_wen = w0; v.m0_addr = a0; v.m0_wdata = d0;
    v.m1_req = q1; v.m1_wen = w1; v.m1_addr = a1; v.m1_wdata = d1; v.m1_lock = lk; v.exp = e;
    return v;
  endfunction

  function automatic out_t sample();
    out_t o;
    o.m0_gnt = m0_gnt; o.m1_gnt = m1_gnt; o.m0_err = m0_err; o.m1_err = m1_err;
    o.m0_stall = m0_stall; o.mem_ena = mem_ena; o.mem_wena = mem_wena; o.locked = locked;
    o.m0_rdata = m0_rdata; o.m1_rdata = m1_rdata; o.addr_in = mem_addr_in; o.addr_out = mem_addr_out;
    return o;
  endfunction

  task automatic compare(input string n, input out_t act, input out_t e);
    checks++;
    if (act !== e) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, act, e);
    end
  endtask

  // Drive one cycle's inputs at negedge, queue the expectation, check mid-cycle.
  task automatic step(input vec_t v);
    out_t  e;
    string n;
    @(negedge clk);
    rst = v.rst;
    m0_req = v.m0_req; m0_wen = v.m0_wen; m0_addr = v.m0_addr; m0_wdata = v.m0_wdata;
    m1_req = v.m1_req; m1_wen = v.m1_wen; m1_addr = v.m1_addr; m1_wdata = v.m1_wdata;
    m1_lock = v.m1_lock;
    exp_q.push_back(v.exp);
    name_q.push_back(v.name);
    #1;
    e = exp_q.pop_front();
    n = name_q.pop_front();
    compare(n, sample(), e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    rst = 1'b0;
    m0_req = 1'b0; m0_wen = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_wen = 1'b0; m1_addr = '0; m1_wdata = '0; m1_lock = 1'b0;

    tbl.push_back(mk("rst_hold0", 0, 1,1,A,32'hDEADBEEF, 1,0,B,0, 0, ex(0,0,0,0,0,0,0,0, 0,0,0)));
    tbl.push_back(mk("rst_hold1", 0, 1,1,A,32'hDEADBEEF, 1,0,B,0, 0, ex(0,0,0,0,0,0,0,0, 0,0,0)));
    tbl.push_back(mk("rst_release_m0_store", 1, 1,1,A,32'hDEADBEEF, 1,0,B,0, 0,
                     ex(1,0,0,0,0,1,1,0, 0,0,A)));
    tbl.push_back(mk("m0_load_back", 1, 1,0,A,0, 0,0,0,0, 0, ex(1,0,0,0,0,1,0,0, 32'hDEADBEEF,0,A)));
    tbl.push_back(mk("fault_misalign", 1, 1,0,B+2,0, 0,0,0,0, 0, ex(1,0,1,0,0,0,0,0, 0,0,B+2)));
    tbl.push_back(mk("fault_below", 1, 1,0,32'h1000FFFC,0, 0,0,0,0, 0,
                     ex(1,0,1,0,0,0,0,0, 0,0,32'h1000FFFC)));
    tbl.push_back(mk("fault_above", 1, 1,0,32'h10011000,0, 0,0,0,0, 0,
                     ex(1,0,1,0,0,0,0,0, 0,0,32'h10011000)));
    tbl.push_back(mk("load_after_faults", 1, 1,0,A,0, 0,0,0,0, 0, ex(1,0,0,0,0,1,0,0, 32'hDEADBEEF,0,A)));
    tbl.push_back(mk("store_last_word", 1, 1,1,B+32'hFFC,32'hCAFEF00D, 0,0,0,0, 0,
                     ex(1,0,0,0,0,1,1,0, 0,0,B+32'hFFC)));
    tbl.push_back(mk("load_last_word", 1, 1,0,B+32'hFFC,0, 0,0,0,0, 0,
                     ex(1,0,0,0,0,1,0,0, 32'hCAFEF00D,0,B+32'hFFC)));
    tbl.push_back(mk("store_misaligned", 1, 1,1,32'h10010011,32'h0BADBAD0, 0,0,0,0, 0,
                     ex(1,0,1,0,0,0,0,0, 0,0,32'h10010011)));
    tbl.push_back(mk("no_write_on_fault", 1, 1,0,A,0, 0,0,0,0, 0, ex(1,0,0,0,0,1,0,0, 32'hDEADBEEF,0,A)));
    tbl.push_back(mk("store_first_word", 1, 1,1,B,32'h12345678, 0,0,0,0, 0, ex(1,0,0,0,0,1,1,0, 0,0,B)));
    tbl.push_back(mk("m1_load_alone", 1, 0,0,0,0, 1,0,B,0, 0, ex(0,1,0,0,0,1,0,0, 0,32'h12345678,B)));
    tbl.push_back(mk("m1_store_fault", 1, 0,0,0,0, 1,1,B+32'hFFE,32'h55, 0,
                     ex(0,1,0,1,0,0,0,0, 0,0,B+32'hFFE)));
    tbl.push_back(mk("conflict_m0_wins", 1, 1,1,A,32'h11111111, 1,0,A,0, 0, ex(1,0,0,0,0,1,1,0, 0,0,A)));
    tbl.push_back(mk("m1_sees_m0_store", 1, 0,0,0,0, 1,0,A,0, 0, ex(0,1,0,0,0,1,0,0, 0,32'h11111111,A)));
    tbl.push_back(mk("idle", 1, 0,0,0,0, 0,0,0,0, 0, ex(0,0,0,0,0,0,0,0, 0,0,0)));

    foreach (tbl[i]) step(tbl[i]);

    // Starvation: m1 wins exactly every 9th cycle with both requests held.
    for (int k = 1; k <= 18; k++) begin
      if (k % 9 == 0)
        step(mk($sformatf("starve_c%0d", k), 1, 1,0,A,0, 1,0,B,0, 0,
                 ex(0,1,0,0,1,1,0,0, 0,32'h12345678,B)));
      else
        step(mk($sformatf("starve_c%0d", k), 1, 1,0,A,0, 1,0,B,0, 0,
                 ex(1,0,0,0,0,1,0,0, 32'h11111111,0,A)));
    end

    // Locked burst: m1 waits out the threshold, then owns 4 consecutive cycles.
    for (int k = 1; k <= 8; k++)
      step(mk($sformatf("burst_wait%0d", k), 1, 1,0,A,0, 1,1,32'h10010100,32'hB0000000, 1,
               ex(1,0,0,0,0,1,0,0, 32'h11111111,0,A)));
    for (int i = 0; i < 4; i++)
      step(mk($sformatf("burst_w%0d", i), 1, 1,0,A,0, 1,1,32'h10010100 + 32'(4*i),32'hB0000000 + 32'(i),
               bit'(i < 3), ex(0,1,0,0,1,1,1,bit'(i > 0), 0,0,32'h10010100 + 32'(4*i))));
    step(mk("burst_m0_resumes", 1, 1,0,A,0, 0,0,0,0, 0, ex(1,0,0,0,0,1,0,0, 32'h11111111,0,A)));
    for (int i = 0; i < 4; i++)
      step(mk($sformatf("burst_rb%0d", i), 1, 0,0,0,0, 1,0,32'h10010100 + 32'(4*i),0, 0,
               ex(0,1,0,0,0,1,0,0, 0,32'hB0000000 + 32'(i),32'h10010100 + 32'(4*i))));

    // Asynchronous reset while LOCKED, with a store pending in that cycle.
    step(mk("lock_w0", 1, 0,0,0,0, 1,1,32'h10010200,32'hAAAA0001, 1,
            ex(0,1,0,0,0,1,1,0, 0,0,32'h10010200)));
    step(mk("lock_w1", 1, 1,0,A,0, 1,1,32'h10010204,32'hAAAA0002, 1,
            ex(0,1,0,0,1,1,1,1, 0,0,32'h10010204)));
    #1 rst = 1'b0;
    #1 compare("async_rst_mid_lock", sample(), ex(0,0,0,0,0,0,0,0, 0,0,0));
    step(mk("rst_held", 0, 1,0,A,0, 1,1,32'h10010204,32'hAAAA0002, 1, ex(0,0,0,0,0,0,0,0, 0,0,0)));
    step(mk("post_rst_m0_wins", 1, 1,0,A,0, 1,0,32'h10010204,0, 0,
            ex(1,0,0,0,0,1,0,0, 32'h11111111,0,A)));
    step(mk("pending_store_dropped", 1, 0,0,0,0, 1,0,32'h10010204,0, 0,
            ex(0,1,0,0,0,1,0,0, 0,0,32'h10010204)));
    step(mk("pre_rst_store_kept", 1, 0,0,0,0, 1,0,32'h10010200,0, 0,
            ex(0,1,0,0,0,1,0,0, 0,32'hAAAA0001,32'h10010200)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
